// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD attribute text buffer.
// Fill-engine states and the default cell layout.
package osd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL
    } osd_fill_state_t;

    localparam int ATTR_W_DEF = 4;

    // Space character with all attribute bits clear.
    localparam logic [7+ATTR_W_DEF:0] BLANK_CELL = {8'h20, {ATTR_W_DEF{1'b0}}};

endpackage

// File: rtl/osd_cell_ram.sv
// Simple dual-port cell RAM: one write port and a registered read port.
// Same-address read and write in one cycle returns the old word.
module osd_cell_ram #(
    parameter int DEPTH = 800,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/osd_attr_textbuf.sv
// Character + attribute VRAM addressed by (column, row) with a
// clear/scroll fill engine built on a circular top-row offset.
module osd_attr_textbuf
    import osd_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 20,
    parameter int ATTR_W = ATTR_W_DEF,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [CW-1:0]     rd_col,
    input  logic [RW-1:0]     rd_row,
    output logic              rd_valid,
    output logic [7:0]        rd_char,
    output logic [ATTR_W-1:0] rd_attr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CW-1:0]     wr_col,
    input  logic [RW-1:0]     wr_row,
    input  logic [7:0]        wr_char,
    input  logic [ATTR_W-1:0] wr_attr,
    input  logic              cmd_clear,
    input  logic              cmd_scroll,
    input  logic [7:0]        fill_char,
    input  logic [ATTR_W-1:0] fill_attr,
    output logic              busy,
    output logic [RW-1:0]     top_row
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8 + ATTR_W;
    localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);

    osd_fill_state_t state, state_nx;

    logic [AW-1:0] cnt;
    logic [RW-1:0] clr_row;
    logic [DW-1:0] fill;
    logic          rd_oor;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    function automatic logic [RW-1:0] map_row(input logic [RW-1:0] row,
                                              input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
        return sum[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_idx(input logic [RW-1:0] prow,
                                               input logic [CW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    logic rd_in, wr_in;
    assign rd_in = ({1'b0, rd_col} < (CW+1)'(COLS)) && ({1'b0, rd_row} < (RW+1)'(ROWS));
    assign wr_in = ({1'b0, wr_col} < (CW+1)'(COLS)) && ({1'b0, wr_row} < (RW+1)'(ROWS));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_clear)       state_nx = CLEAR;
                else if (cmd_scroll) state_nx = SCROLL;
            end
            CLEAR:   if (cnt == LAST_CELL) state_nx = IDLE;
            SCROLL:  if (cnt == LAST_COL) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        eng_we   = busy;
        eng_addr = (state == SCROLL) ? AW'(clr_row) * AW'(COLS) + cnt : cnt;
        // Engine owns the write port while busy; nothing lands during reset.
        if (eng_we) begin
            ram_we    = !rst;
            ram_waddr = eng_addr;
            ram_wdata = fill;
        end else begin
            ram_we    = wr_valid && wr_in && !rst;
            ram_waddr = cell_idx(map_row(wr_row, top_row), wr_col);
            ram_wdata = {wr_char, wr_attr};
        end
    end

    assign wr_ready = !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            top_row  <= '0;
            cnt      <= '0;
            clr_row  <= '0;
            fill     <= '0;
            rd_valid <= 1'b0;
            rd_oor   <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_oor <= !rd_in;
            if (state == IDLE) begin
                cnt <= '0;
                if (cmd_clear) begin
                    fill    <= {fill_char, fill_attr};
                    top_row <= '0;
                end else if (cmd_scroll) begin
                    fill    <= {fill_char, fill_attr};
                    clr_row <= top_row;
                    top_row <= (top_row == RW'(ROWS - 1)) ? '0 : top_row + RW'(1);
                end
            end else begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    osd_cell_ram #(
        .DEPTH(DEPTH),
        .WIDTH(DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_en && rd_in),
        .raddr (cell_idx(map_row(rd_row, top_row), rd_col)),
        .rdata (ram_rdata)
    );

    // Out-of-range (and post-reset) reads present a zero cell.
    assign rd_char = rd_oor ? 8'h00 : ram_rdata[DW-1:ATTR_W];
    assign rd_attr = rd_oor ? '0 : ram_rdata[ATTR_W-1:0];

endmodule

// File: tb/tb_osd_attr_textbuf.sv
// Self-checking bench for osd_attr_textbuf against a logical-screen model
// where scrolling shifts rows up and clearing fills every cell.
module tb_osd_attr_textbuf;

    localparam int COLS = 40;
    localparam int ROWS = 20;
    localparam int ATTR_W = 4;
    localparam int CW = 6;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_en = 1'b0;
    logic [CW-1:0]     rd_col = '0;
    logic [RW-1:0]     rd_row = '0;
    logic              rd_valid;
    logic [7:0]        rd_char;
    logic [ATTR_W-1:0] rd_attr;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [CW-1:0]     wr_col = '0;
    logic [RW-1:0]     wr_row = '0;
    logic [7:0]        wr_char = '0;
    logic [ATTR_W-1:0] wr_attr = '0;
    logic              cmd_clear = 1'b0;
    logic              cmd_scroll = 1'b0;
    logic [7:0]        fill_char = '0;
    logic [ATTR_W-1:0] fill_attr = '0;
    logic              busy;
    logic [RW-1:0]     top_row;

    logic [11:0] scr [ROWS][COLS];
    int          top_m = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    osd_attr_textbuf #(.COLS(COLS), .ROWS(ROWS), .ATTR_W(ATTR_W)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
        .rd_valid(rd_valid), .rd_char(rd_char), .rd_attr(rd_attr),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_attr(wr_attr),
        .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll),
        .fill_char(fill_char), .fill_attr(fill_attr),
        .busy(busy), .top_row(top_row)
    );

    function automatic logic [11:0] model_at(input int c, input int r);
        if (c < COLS && r < ROWS) return scr[r][c];
        return 12'h000;
    endfunction

    function automatic void model_clear(input logic [11:0] f);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = f;
        top_m = 0;
    endfunction

    function automatic void model_scroll(input logic [11:0] f);
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = f;
        top_m = (top_m + 1) % ROWS;
    endfunction

    task automatic do_write(input int c, input int r, input logic [7:0] ch,
                            input logic [3:0] at);
        wr_valid = 1'b1;
        wr_col = CW'(c);
        wr_row = RW'(r);
        wr_char = ch;
        wr_attr = at;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input int c, input int r, output logic v,
                           output logic [11:0] d);
        rd_en = 1'b1;
        rd_col = CW'(c);
        rd_row = RW'(r);
        @(negedge clk);
        rd_en = 1'b0;
        v = rd_valid;
        d = {rd_char, rd_attr};
    endtask

    // Issues a command and counts the cycles busy stays high.
    task automatic run_cmd(input bit clr, input bit scl, input logic [7:0] fc,
                           input logic [3:0] fa, output int n,
                           output logic [RW-1:0] tr0);
        cmd_clear = clr;
        cmd_scroll = scl;
        fill_char = fc;
        fill_attr = fa;
        @(negedge clk);
        cmd_clear = 1'b0;
        cmd_scroll = 1'b0;
        tr0 = top_row;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_valid, rd_char, rd_attr} !== 13'h0) begin
            failures++;
            $display("FAIL reset_rd got v=%b %h/%h want 0", rd_valid, rd_char, rd_attr);
        end
        checks++;
        if ({busy, wr_ready, top_row} !== {1'b0, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL reset_ctl got busy=%b ready=%b top=%0d want 0/1/0",
                     busy, wr_ready, top_row);
        end
    endtask

    task automatic test_write_read;
        logic v;
        logic [11:0] d;
        do_write(5, 3, 8'h41, 4'h3);
        scr[3][5] = 12'h413;
        do_write(0, 4, 8'h11, 4'h1);
        scr[4][0] = 12'h111;
        do_read(5, 3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 12'h413) begin
            failures++;
            $display("FAIL write_read got v=%b %h want 1 413", v, d);
        end
        do_write(40, 3, 8'hAA, 4'hA);
        do_write(3, 20, 8'hBB, 4'hB);
        do_read(0, 4, v, d);
        checks++;
        if (d !== 12'h111) begin
            failures++;
            $display("FAIL oor_write_alias got %h want 111", d);
        end
        do_read(40, 3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 12'h000) begin
            failures++;
            $display("FAIL oor_read_col got v=%b %h want 1 000", v, d);
        end
        do_read(3, 20, v, d);
        checks++;
        if (d !== 12'h000) begin
            failures++;
            $display("FAIL oor_read_row got %h want 000", d);
        end
    endtask

    task automatic test_clear;
        int n;
        bit ready_seen;
        logic v;
        logic [11:0] d;
        cmd_clear = 1'b1;
        fill_char = 8'h20;
        fill_attr = 4'h0;
        @(negedge clk);
        cmd_clear = 1'b0;
        n = 0;
        ready_seen = 1'b0;
        // External writes offered during the clear must be refused.
        wr_valid = 1'b1;
        wr_col = 6'd1;
        wr_row = 5'd1;
        wr_char = 8'h99;
        wr_attr = 4'h9;
        while (busy && n < 2000) begin
            if (wr_ready) ready_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        model_clear(12'h200);
        checks++;
        if (n !== 800) begin
            failures++;
            $display("FAIL clear_busy_len got %0d want 800", n);
        end
        checks++;
        if (ready_seen !== 1'b0) begin
            failures++;
            $display("FAIL clear_wr_ready got 1 while busy want 0");
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v, d);
                checks++;
                if (v !== 1'b1 || d !== scr[r][c]) begin
                    failures++;
                    $display("FAIL clear_cell (%0d,%0d) got %h want %h", c, r, d, scr[r][c]);
                end
            end
    endtask

    task automatic test_scroll;
        int n;
        logic [RW-1:0] tr0;
        logic v;
        logic [11:0] d;
        logic [7:0] fc;
        logic [3:0] fa;
        do_write(0, 1, 8'h42, 4'h5);
        scr[1][0] = 12'h425;
        run_cmd(1'b0, 1'b1, 8'h2E, 4'h1, n, tr0);
        model_scroll(12'h2E1);
        checks++;
        if (n !== 40 || tr0 !== RW'(top_m)) begin
            failures++;
            $display("FAIL scroll_busy got len=%0d top=%0d want 40 %0d", n, tr0, top_m);
        end
        do_read(0, 0, v, d);
        checks++;
        if (d !== 12'h425) begin
            failures++;
            $display("FAIL scroll_moved got %h want 425", d);
        end
        for (int c = 0; c < COLS; c++) begin
            do_read(c, ROWS - 1, v, d);
            checks++;
            if (d !== 12'h2E1) begin
                failures++;
                $display("FAIL scroll_last_row col %0d got %h want 2e1", c, d);
            end
        end
        for (int k = 0; k < ROWS - 1; k++) begin
            do_write($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1), 8'h30 + 8'(k), 4'(k));
            scr[wr_row][wr_col] = {wr_char, wr_attr};
            fc = 8'($urandom);
            fa = 4'($urandom);
            run_cmd(1'b0, 1'b1, fc, fa, n, tr0);
            model_scroll({fc, fa});
        end
        checks++;
        if (top_row !== 5'd0 || top_m !== 0) begin
            failures++;
            $display("FAIL scroll_wrap got top=%0d want 0", top_row);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v, d);
                checks++;
                if (d !== scr[r][c]) begin
                    failures++;
                    $display("FAIL scroll_screen (%0d,%0d) got %h want %h", c, r, d, scr[r][c]);
                end
            end
    endtask

    task automatic test_cmd_conflict;
        int n;
        logic [RW-1:0] tr0;
        logic v;
        logic [11:0] d;
        run_cmd(1'b0, 1'b1, 8'h2D, 4'h2, n, tr0);
        model_scroll(12'h2D2);
        cmd_clear = 1'b1;
        cmd_scroll = 1'b1;
        fill_char = 8'h55;
        fill_attr = 4'h2;
        @(negedge clk);
        cmd_clear = 1'b0;
        cmd_scroll = 1'b0;
        tr0 = top_row;
        n = 0;
        while (busy && n < 2000) begin
            cmd_scroll = (n == 10);
            fill_char = (n == 10) ? 8'hEE : 8'h55;
            n++;
            @(negedge clk);
        end
        cmd_scroll = 1'b0;
        model_clear(12'h552);
        checks++;
        if (n !== 800 || tr0 !== 5'd0 || top_row !== 5'd0) begin
            failures++;
            $display("FAIL conflict got len=%0d top=%0d/%0d want 800 0/0", n, tr0, top_row);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                do_read(c, r, v, d);
                checks++;
                if (d !== scr[r][c]) begin
                    failures++;
                    $display("FAIL conflict_cell (%0d,%0d) got %h want %h", c, r, d, scr[r][c]);
                end
            end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        logic [RW-1:0] tr0;
        logic v;
        logic [11:0] d;
        do_write(20, 12, 8'h77, 4'h7);
        scr[12][20] = 12'h777;
        cmd_clear = 1'b1;
        fill_char = 8'h3C;
        fill_attr = 4'h9;
        @(negedge clk);
        cmd_clear = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || top_row !== 5'd0) begin
            failures++;
            $display("FAIL midclear_reset got busy=%b top=%0d want 0 0", busy, top_row);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            do_read(i % COLS, i / COLS, v, d);
            checks++;
            if (d !== 12'h3C9) begin
                failures++;
                $display("FAIL midclear_filled cell %0d got %h want 3c9", i, d);
            end
        end
        do_read(20, 12, v, d);
        checks++;
        if (d !== 12'h777) begin
            failures++;
            $display("FAIL midclear_untouched got %h want 777", d);
        end
        run_cmd(1'b1, 1'b0, 8'h20, 4'h0, n, tr0);
        model_clear(12'h200);
    endtask

    task automatic test_back_to_back;
        logic v;
        logic [11:0] d;
        do_write(7, 7, 8'hC1, 4'h4);
        scr[7][7] = 12'hC14;
        rd_en = 1'b1;
        rd_col = 6'd7;
        rd_row = 5'd7;
        do_write(7, 7, 8'hC2, 4'h8);
        rd_en = 1'b0;
        scr[7][7] = 12'hC28;
        checks++;
        if ({rd_char, rd_attr} !== 12'hC14) begin
            failures++;
            $display("FAIL read_first got %h want c14", {rd_char, rd_attr});
        end
        do_read(7, 7, v, d);
        checks++;
        if (d !== 12'hC28) begin
            failures++;
            $display("FAIL read_after_write got %h want c28", d);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || {rd_char, rd_attr} !== 12'hC28) begin
            failures++;
            $display("FAIL read_hold got v=%b %h want 0 c28", rd_valid, {rd_char, rd_attr});
        end
    endtask

    task automatic test_random;
        logic ro, wo;
        int rc, rr, wc, wr;
        logic [11:0] wd;
        logic [11:0] exp_d;
        exp_d = 12'hC28;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rand_ready got %b want 1", wr_ready);
        end
        for (int i = 0; i < 400; i++) begin
            ro = 1'($urandom);
            wo = 1'($urandom);
            rc = $urandom_range(0, 42);
            rr = $urandom_range(0, 21);
            wc = (i % 4 == 0) ? rc : $urandom_range(0, 42);
            wr = (i % 4 == 0) ? rr : $urandom_range(0, 21);
            wd = 12'($urandom);
            rd_en = ro;
            rd_col = CW'(rc);
            rd_row = RW'(rr);
            wr_valid = wo;
            wr_col = CW'(wc);
            wr_row = RW'(wr);
            {wr_char, wr_attr} = wd;
            if (ro) exp_d = model_at(rc, rr);
            if (wo && wc < COLS && wr < ROWS) scr[wr][wc] = wd;
            @(negedge clk);
            checks++;
            if (rd_valid !== ro || {rd_char, rd_attr} !== exp_d) begin
                failures++;
                $display("FAIL rand_read i=%0d got v=%b %h want %b %h",
                         i, rd_valid, {rd_char, rd_attr}, ro, exp_d);
            end
        end
        rd_en = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_clear();
        test_scroll();
        test_cmd_conflict();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
